pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage core. It produces the hold (stall) and bubble (flush) controls for the IF/ID and ID/EX pipeline registers and the PC. It also produces the freeze control for the EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch redirects and data-memory wait states, with a timeout and a stall-cycle performance counter.

---
 rtl/pipeline_ctrl_pkg.sv | 32 +++
 rtl/pipeline_ctrl_if.sv | 51 +++++
 rtl/pipeline_ctrl_hazard_detect.sv | 24 ++
 rtl/pipeline_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the core's hazard/sequencing controller.
// Holds datapath widths, controller states and the control-output bundle.
package pipeline_ctrl_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    // Control outputs grouped so one default assignment clears them all.
    typedef struct packed {
        logic stall_pc;
        logic stall_ifid;
        logic stall_idex;
        logic freeze_mem;
        logic flush_ifid;
        logic flush_idex;
        logic pc_redirect;
        logic mem_err;
    } ctrl_out_t;

    // Loads complete on read data, stores complete on grant.
    function automatic logic dmem_done(input logic is_load, input logic rvalid,
                                       input logic gnt);
        return is_load ? rvalid : gnt;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-status inputs and pipeline-control outputs of pipeline_ctrl.
// master = core datapath side, slave = the controller.
interface pipeline_ctrl_if #(
    parameter int REG_ADDR_WIDTH = pipeline_ctrl_pkg::REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 32
);
    logic [REG_ADDR_WIDTH-1:0] id_rs1_i;
    logic [REG_ADDR_WIDTH-1:0] id_rs2_i;
    logic                      id_use_rs1_i;
    logic                      id_use_rs2_i;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_i;
    logic                      ex_load_i;
    logic                      ex_write_en_i;
    logic                      ex_branch_taken_i;
    logic                      mem_req_i;
    logic                      mem_is_load_i;
    logic                      dmem_gnt_i;
    logic                      dmem_rvalid_i;
    logic                      stall_cnt_clr_i;

    logic                      stall_pc_o;
    logic                      stall_ifid_o;
    logic                      stall_idex_o;
    logic                      freeze_mem_o;
    logic                      flush_ifid_o;
    logic                      flush_idex_o;
    logic                      pc_redirect_o;
    logic                      mem_err_o;
    logic [CNT_WIDTH-1:0]      stall_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_i, ex_load_i, ex_write_en_i, ex_branch_taken_i,
               mem_req_i, mem_is_load_i, dmem_gnt_i, dmem_rvalid_i,
               stall_cnt_clr_i,
        input  stall_pc_o, stall_ifid_o, stall_idex_o, freeze_mem_o,
               flush_ifid_o, flush_idex_o, pc_redirect_o, mem_err_o,
               stall_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_i, ex_load_i, ex_write_en_i, ex_branch_taken_i,
               mem_req_i, mem_is_load_i, dmem_gnt_i, dmem_rvalid_i,
               stall_cnt_clr_i,
        output stall_pc_o, stall_ifid_o, stall_idex_o, freeze_mem_o,
               flush_ifid_o, flush_idex_o, pc_redirect_o, mem_err_o,
               stall_cnt_o
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID operands and the EX destination.
// Purely combinational so a forwarding unit can share it later.
module hazard_detect #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_use_rs1,
    input  logic                      id_use_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_load,
    input  logic                      ex_write_en,
    output logic                      load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = ex_load && ex_write_en && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage core: load-use bubbles,
// branch redirects, data-memory wait states with timeout, stall counter.
module pipeline_ctrl #(
    parameter int REG_ADDR_WIDTH = pipeline_ctrl_pkg::REG_ADDR_WIDTH,
    parameter int FLUSH_CYCLES   = 1,
    parameter int MEM_TIMEOUT    = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);
    import pipeline_ctrl_pkg::*;

    localparam int              TW     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int              FW     = 3;
    localparam logic [TW-1:0]   T_LAST = TW'(MEM_TIMEOUT - 1);
    localparam logic [FW-1:0]   F_LOAD = FW'(FLUSH_CYCLES - 1);

    ctrl_state_t          state_q, state_d;
    logic [FW-1:0]        fcnt_q, fcnt_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [CNT_WIDTH-1:0] scnt_q;

    ctrl_out_t o;
    logic      load_use;
    logic      done;
    logic      timeout;
    logic      freeze;
    logic      flushing;

    hazard_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard (
        .id_rs1      (bus.id_rs1_i),
        .id_rs2      (bus.id_rs2_i),
        .id_use_rs1  (bus.id_use_rs1_i),
        .id_use_rs2  (bus.id_use_rs2_i),
        .ex_rd       (bus.ex_rd_i),
        .ex_load     (bus.ex_load_i),
        .ex_write_en (bus.ex_write_en_i),
        .load_use    (load_use)
    );

    assign done     = dmem_done(bus.mem_is_load_i, bus.dmem_rvalid_i, bus.dmem_gnt_i);
    assign timeout  = (state_q == MEM_WAIT) && !done && (tcnt_q == T_LAST);
    // The timeout cycle drops the freeze so its flushes can take effect.
    assign freeze   = !timeout && !done && ((state_q == MEM_WAIT) || bus.mem_req_i);
    // A nonzero flush count means flushing is pending, even across a MEM_WAIT.
    assign flushing = (fcnt_q != '0);

    always_comb begin
        o       = '0;
        state_d = state_q;
        fcnt_d  = fcnt_q;
        tcnt_d  = '0;
        if (timeout) begin
            o.mem_err    = 1'b1;
            o.flush_ifid = 1'b1;
            o.flush_idex = 1'b1;
            state_d      = RUN;
            fcnt_d       = '0;
        end else if (freeze) begin
            o.stall_pc   = 1'b1;
            o.stall_ifid = 1'b1;
            o.stall_idex = 1'b1;
            o.freeze_mem = 1'b1;
            state_d      = MEM_WAIT;
            tcnt_d       = (state_q == MEM_WAIT) ? tcnt_q + TW'(1) : TW'(1);
        end else if (bus.ex_branch_taken_i) begin
            o.pc_redirect = 1'b1;
            o.flush_ifid  = 1'b1;
            o.flush_idex  = 1'b1;
            fcnt_d        = F_LOAD;
            state_d       = (F_LOAD != '0) ? FLUSH : RUN;
        end else if (load_use) begin
            o.stall_pc   = 1'b1;
            o.stall_ifid = 1'b1;
            o.flush_idex = 1'b1;
            state_d      = flushing ? FLUSH : RUN;
        end else if (flushing) begin
            o.flush_ifid = 1'b1;
            fcnt_d       = fcnt_q - FW'(1);
            state_d      = (fcnt_q > FW'(1)) ? FLUSH : RUN;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            tcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            tcnt_q  <= tcnt_d;
            if (bus.stall_cnt_clr_i)
                scnt_q <= '0;
            else if (o.stall_pc && !(&scnt_q))
                scnt_q <= scnt_q + CNT_WIDTH'(1);
        end
    end

    // Outputs are forced low for the whole reset window.
    assign bus.stall_pc_o    = !rst && o.stall_pc;
    assign bus.stall_ifid_o  = !rst && o.stall_ifid;
    assign bus.stall_idex_o  = !rst && o.stall_idex;
    assign bus.freeze_mem_o  = !rst && o.freeze_mem;
    assign bus.flush_ifid_o  = !rst && o.flush_ifid;
    assign bus.flush_idex_o  = !rst && o.flush_idex;
    assign bus.pc_redirect_o = !rst && o.pc_redirect;
    assign bus.mem_err_o     = !rst && o.mem_err;
    assign bus.stall_cnt_o   = rst ? '0 : scnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl; the stimulus pushes expected
// outputs into a queue and a negedge monitor pops and compares them.
module tb_pipeline_ctrl;

    localparam int CW   = 7;
    localparam int CMAX = (1 << CW) - 1;

    // Bit order: stall_pc stall_ifid stall_idex freeze_mem flush_ifid flush_idex redirect mem_err
    localparam logic [7:0] IDLE = 8'h00;
    localparam logic [7:0] FRZ  = 8'hF0;
    localparam logic [7:0] LU   = 8'hC4;
    localparam logic [7:0] BR   = 8'h0E;
    localparam logic [7:0] FL   = 8'h08;
    localparam logic [7:0] TO   = 8'h0D;

    typedef struct {
        string          name;
        logic [7:0]     vec;
        logic [CW-1:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) bus ();

    pipeline_ctrl #(
        .REG_ADDR_WIDTH (5),
        .FLUSH_CYCLES   (2),
        .MEM_TIMEOUT    (64),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       sb[$];
    exp_t       mon_x;
    logic [7:0] mon_got;
    int         checks   = 0;
    int         failures = 0;
    int         exp_cnt  = 0;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_x   = sb.pop_front();
            mon_got = {bus.stall_pc_o, bus.stall_ifid_o, bus.stall_idex_o, bus.freeze_mem_o,
                       bus.flush_ifid_o, bus.flush_idex_o, bus.pc_redirect_o, bus.mem_err_o};
            checks++;
            if (mon_got !== mon_x.vec) begin
                failures++;
                $display("FAIL %s ctrl got=%b exp=%b", mon_x.name, mon_got, mon_x.vec);
            end
            checks++;
            if (bus.stall_cnt_o !== mon_x.cnt) begin
                failures++;
                $display("FAIL %s stall_cnt got=%0d exp=%0d", mon_x.name, bus.stall_cnt_o, mon_x.cnt);
            end
        end
    end

    task automatic idle_inputs();
        bus.id_rs1_i          = '0;
        bus.id_rs2_i          = '0;
        bus.id_use_rs1_i      = 1'b0;
        bus.id_use_rs2_i      = 1'b0;
        bus.ex_rd_i           = '0;
        bus.ex_load_i         = 1'b0;
        bus.ex_write_en_i     = 1'b0;
        bus.ex_branch_taken_i = 1'b0;
        bus.mem_req_i         = 1'b0;
        bus.mem_is_load_i     = 1'b0;
        bus.dmem_gnt_i        = 1'b0;
        bus.dmem_rvalid_i     = 1'b0;
        bus.stall_cnt_clr_i   = 1'b0;
    endtask

    // Queue the expected response for the current inputs, then advance a cycle.
    task automatic cyc(input string nm, input logic [7:0] e);
        exp_t x;
        x.name = nm;
        x.vec  = e;
        x.cnt  = rst ? '0 : CW'(exp_cnt);
        sb.push_back(x);
        if (rst || bus.stall_cnt_clr_i) exp_cnt = 0;
        else if (e[7] && exp_cnt < CMAX) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic u1, input logic [4:0] rs2, input logic u2);
        bus.ex_load_i     = 1'b1;
        bus.ex_write_en_i = 1'b1;
        bus.ex_rd_i       = rd;
        bus.id_rs1_i      = rs1;
        bus.id_use_rs1_i  = u1;
        bus.id_rs2_i      = rs2;
        bus.id_use_rs2_i  = u2;
    endtask

    task automatic store_timeout(input string nm);
        idle_inputs();
        bus.mem_req_i = 1'b1;
        for (int i = 0; i < 63; i++) cyc({nm, "_wait"}, FRZ);
        cyc({nm, "_err"}, TO);
        idle_inputs();
        cyc({nm, "_after"}, IDLE);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        bus.mem_req_i         = 1'b1;
        bus.ex_branch_taken_i = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset0", IDLE);
        cyc("reset1", IDLE);
        rst = 1'b0;
        idle_inputs();
        cyc("post_reset", IDLE);

        // Load x5 in EX, ID reads rs2=x5
        set_load_use(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
        cyc("lu_rs2", LU);
        idle_inputs();
        cyc("lu_rs2_next", IDLE);

        set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        cyc("lu_x0", IDLE);
        set_load_use(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        cyc("lu_unused_rs1", IDLE);
        set_load_use(5'd7, 5'd7, 1'b1, 5'd3, 1'b0);
        cyc("lu_rs1", LU);
        set_load_use(5'd7, 5'd7, 1'b1, 5'd3, 1'b0);
        bus.ex_write_en_i = 1'b0;
        cyc("lu_no_wen", IDLE);
        idle_inputs();

        bus.ex_branch_taken_i = 1'b1;
        cyc("br_c0", BR);
        idle_inputs();
        cyc("br_c1", FL);
        cyc("br_c2", IDLE);

        set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        bus.ex_branch_taken_i = 1'b1;
        cyc("br_over_lu", BR);
        idle_inputs();
        cyc("br_over_lu_c1", FL);
        cyc("br_over_lu_c2", IDLE);

        // Load in MEM: gnt at cycle 0, rvalid at cycle 3, branch during 1-3
        bus.mem_req_i     = 1'b1;
        bus.mem_is_load_i = 1'b1;
        bus.dmem_gnt_i    = 1'b1;
        cyc("ld_c0", FRZ);
        bus.dmem_gnt_i        = 1'b0;
        bus.ex_branch_taken_i = 1'b1;
        cyc("ld_c1", FRZ);
        cyc("ld_c2", FRZ);
        bus.dmem_rvalid_i = 1'b1;
        cyc("ld_c3", BR);
        idle_inputs();
        cyc("ld_c4", FL);
        cyc("ld_c5", IDLE);

        store_timeout("to1");

        // Reset in the middle of MEM_WAIT
        bus.mem_req_i = 1'b1;
        cyc("rstw_c0", FRZ);
        cyc("rstw_c1", FRZ);
        rst = 1'b1;
        cyc("rstw_rst", IDLE);
        rst = 1'b0;
        idle_inputs();
        cyc("rstw_after", IDLE);

        set_load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        cyc("clr_a", LU);
        bus.stall_cnt_clr_i = 1'b1;
        cyc("clr_b", LU);
        idle_inputs();
        cyc("clr_after", IDLE);

        // Three back-to-back timeouts push the 7-bit counter into saturation
        store_timeout("sat1");
        store_timeout("sat2");
        store_timeout("sat3");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
